// File: rtl/envelope_generator_pkg.sv
// Shared types and constants for the ADSR envelope stage: state encoding,
// descriptor field layout and level arithmetic constants.
package envelope_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ATTACK  = 3'd3,
    ST_DECAY   = 3'd4,
    ST_SUSTAIN = 3'd5,
    ST_RELEASE = 3'd6
  } env_state_e;

  localparam int A_POS = 12;
  localparam int D_POS = 8;
  localparam int S_POS = 4;
  localparam int R_POS = 0;

  localparam logic [7:0] LEVEL_MAX   = 8'd255;
  localparam int         STEP_SHIFT  = 2;
  localparam logic [8:0] SUSTAIN_MUL = 9'd17;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] s;
    logic [3:0] r;
  } env_param_t;

  function automatic env_param_t unpack_desc(input logic [15:0] w);
    env_param_t p;
    p.a = w[A_POS +: 4];
    p.d = w[D_POS +: 4];
    p.s = w[S_POS +: 4];
    p.r = w[R_POS +: 4];
    return p;
  endfunction

  function automatic logic [7:0] sustain_level(input logic [3:0] s);
    logic [8:0] prod;
    prod = {5'd0, s} * SUSTAIN_MUL;
    return prod[7:0];
  endfunction

endpackage

// File: rtl/envelope_step.sv
// Combinational saturating level step: moves level toward target by
// nibble<<STEP_SHIFT, clamps at the target, flags arrival.
module envelope_step
  import envelope_generator_pkg::*;
(
  input  logic [7:0] level,
  input  logic [3:0] step_nib,
  input  logic [7:0] target,
  input  logic       dir_up,
  output logic [7:0] next_level,
  output logic       reached
);

  logic [8:0] step;
  logic [8:0] sum;
  logic [8:0] lim;

  always_comb begin
    step       = {5'd0, step_nib} << STEP_SHIFT;
    sum        = '0;
    lim        = '0;
    next_level = target;
    if (step_nib != 4'd0) begin
      if (dir_up) begin
        sum        = {1'b0, level} + step;
        next_level = (sum >= {1'b0, target}) ? target : sum[7:0];
      end else begin
        // compare against target+step so the subtraction never underflows
        lim        = {1'b0, target} + step;
        next_level = ({1'b0, level} <= lim) ? target : (level - step[7:0]);
      end
    end
    reached = (next_level == target);
  end

endmodule

// File: rtl/envelope_generator.sv
// Per-channel ADSR envelope: fetches an instrument descriptor from an external
// sync ROM on note start, then steps the level on each enable strobe.
module envelope_generator
  import envelope_generator_pkg::*;
#(
  parameter INSTRUMENT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_enable,
  input  logic        i_release,
  input  logic [3:0]  i_instrument,
  output logic [3:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [7:0]  o_level,
  output logic        o_active,
  output logic        o_valid
);

  // image name is carried for documentation; the ROM lives in the channel top
  if (INSTRUMENT_FILE == "") begin : g_no_image
  end

  env_state_e state, state_nxt;
  env_param_t par, par_nxt;
  logic [7:0] level, level_nxt;
  logic [3:0] rom_addr, rom_addr_nxt;
  logic       pend, pend_nxt;
  logic       valid, valid_nxt;

  logic [3:0] step_nib;
  logic [7:0] step_tgt;
  logic       step_up;
  logic [7:0] step_level;
  logic       step_reached;

  always_comb begin
    step_nib = '0;
    step_tgt = level;
    step_up  = 1'b0;
    case (state)
      ST_ATTACK:  begin step_nib = par.a; step_tgt = LEVEL_MAX; step_up = 1'b1; end
      ST_DECAY:   begin step_nib = par.d; step_tgt = sustain_level(par.s); end
      ST_RELEASE: begin step_nib = par.r; step_tgt = '0; end
      default: ;
    endcase
  end

  envelope_step u_step (
    .level      (level),
    .step_nib   (step_nib),
    .target     (step_tgt),
    .dir_up     (step_up),
    .next_level (step_level),
    .reached    (step_reached)
  );

  always_comb begin
    state_nxt    = state;
    par_nxt      = par;
    level_nxt    = level;
    rom_addr_nxt = rom_addr;
    pend_nxt     = pend;
    valid_nxt    = 1'b0;
    if (i_load) begin
      // hard retrigger from any state; a coincident release is dropped
      rom_addr_nxt = i_instrument;
      level_nxt    = '0;
      pend_nxt     = 1'b0;
      state_nxt    = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_release) pend_nxt = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          par_nxt   = unpack_desc(i_rom_data);
          valid_nxt = 1'b1;
          pend_nxt  = 1'b0;
          state_nxt = (pend || i_release) ? ST_RELEASE : ST_ATTACK;
        end
        ST_ATTACK, ST_DECAY: begin
          if (i_release) begin
            state_nxt = ST_RELEASE;
          end else if (i_enable) begin
            level_nxt = step_level;
            if (step_reached) state_nxt = (state == ST_ATTACK) ? ST_DECAY : ST_SUSTAIN;
          end
        end
        ST_SUSTAIN: begin
          if (i_release) state_nxt = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (i_enable) begin
            level_nxt = step_level;
            if (step_reached) state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      par      <= '0;
      level    <= '0;
      rom_addr <= '0;
      pend     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      par      <= par_nxt;
      level    <= level_nxt;
      rom_addr <= rom_addr_nxt;
      pend     <= pend_nxt;
      valid    <= valid_nxt;
    end
  end

  assign o_rom_addr = rom_addr;
  assign o_level    = level;
  assign o_active   = (state != ST_IDLE);
  assign o_valid    = valid;

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboarded bench for envelope_generator: an arithmetic ADSR model queues
// the expected outputs per cycle, a monitor pops and compares them.
module tb_envelope_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld = 1'b0, en = 1'b0, rel = 1'b0;
  logic [3:0]  inst = '0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  level;
  logic        active, valid;
  bit          clk_run = 1'b1;

  logic [15:0] rom [16];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {int lvl; int act; int vld; int addr;} exp_t;
  exp_t q[$];

  envelope_generator #(.INSTRUMENT_FILE("")) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(ld), .i_enable(en), .i_release(rel),
    .i_instrument(inst), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_level(level), .o_active(active), .o_valid(valid)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
    else clk = 1'b0;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 fetch, 2 wait, 3 attack, 4 decay, 5 sustain, 6 release
  int m_ph = 0, m_lvl = 0, m_addr = 0;
  int m_a = 0, m_d = 0, m_s = 0, m_r = 0;
  bit m_pend = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int ph, lv, ad, a, d, s, r, tgt, vd;
    bit pd;
    if (!rst_n) begin
      m_ph <= 0; m_lvl <= 0; m_addr <= 0; m_pend <= 0;
      m_a <= 0; m_d <= 0; m_s <= 0; m_r <= 0;
      q.delete();
    end else begin
      ph = m_ph; lv = m_lvl; ad = m_addr; pd = m_pend;
      a = m_a; d = m_d; s = m_s; r = m_r; vd = 0;
      if (ld) begin
        ad = int'(inst); lv = 0; pd = 0; ph = 1;
      end else if (ph == 1) begin
        if (rel) pd = 1;
        ph = 2;
      end else if (ph == 2) begin
        a = int'(rom[ad][15:12]); d = int'(rom[ad][11:8]);
        s = int'(rom[ad][7:4]);   r = int'(rom[ad][3:0]);
        vd = 1;
        ph = (pd || rel) ? 6 : 3;
        pd = 0;
      end else if (ph >= 3 && ph <= 5 && rel) begin
        ph = 6;
      end else if (en) begin
        if (ph == 3) begin
          lv = (a == 0 || lv + 4 * a > 255) ? 255 : lv + 4 * a;
          if (lv == 255) ph = 4;
        end else if (ph == 4) begin
          tgt = 17 * s;
          lv = (d == 0 || lv - 4 * d < tgt) ? tgt : lv - 4 * d;
          if (lv == tgt) ph = 5;
        end else if (ph == 6) begin
          lv = (r == 0 || lv - 4 * r < 0) ? 0 : lv - 4 * r;
          if (lv == 0) ph = 0;
        end
      end
      m_ph <= ph; m_lvl <= lv; m_addr <= ad; m_pend <= pd;
      m_a <= a; m_d <= d; m_s <= s; m_r <= r;
      q.push_back('{lvl: lv, act: int'(ph != 0), vld: vd, addr: ad});
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("level", int'(level), e.lvl);
      check("active", int'(active), e.act);
      check("valid", int'(valid), e.vld);
      check("rom_addr", int'(rom_addr), e.addr);
    end
  end

  task automatic cyc(input bit l, input bit e, input bit r, input logic [3:0] i);
    ld = l; en = e; rel = r; inst = i;
    @(negedge clk);
    ld = 0; en = 0; rel = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 4'd0);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      idle(gap - 1);
      cyc(0, 1, 0, 4'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    rom[3] = 16'h4281;
    rom[5] = 16'h00F0;
    rom[7] = 16'h8421;
    rom[0] = 16'h0000;

    #23;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // full envelope: 16 attack, 15 decay, sustain, 34 release ticks
    cyc(1, 0, 0, 4'd3); idle(3);
    ticks(16, 4); ticks(15, 4); ticks(3, 4);
    cyc(0, 0, 1, 4'd0);
    ticks(34, 4); idle(3);

    // instant steps with S=F
    cyc(1, 0, 0, 4'd5); idle(3);
    ticks(2, 4); ticks(1, 2);
    cyc(0, 0, 1, 4'd0);
    ticks(1, 2); idle(2);

    // early release in WAIT
    cyc(1, 0, 0, 4'd3); cyc(0, 0, 0, 4'd0); cyc(0, 0, 1, 4'd0);
    idle(1); ticks(1, 2); idle(2);

    // retrigger mid-decay onto a different instrument
    cyc(1, 0, 0, 4'd3); idle(3);
    ticks(18, 1);
    cyc(1, 0, 0, 4'd7); idle(3);
    ticks(5, 1); idle(2);

    // load+release collision, then release+enable in sustain
    cyc(1, 0, 1, 4'd5); idle(3);
    ticks(2, 1);
    cyc(0, 1, 1, 4'd0);
    ticks(1, 1); idle(2);

    // async reset mid-attack with the clock stopped
    cyc(1, 0, 0, 4'd3); idle(3);
    ticks(4, 2);
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async");
    #10;
    rst_n = 1'b1;
    #3;
    clk_run = 1'b1;
    @(negedge clk);
    idle(3);

    // randomized traffic
    repeat (3000)
      cyc($urandom_range(0, 119) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 59) == 0, 4'($urandom));
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
